instruction_memory_loader: RTL and testbench

Parametrised, loadable instruction memory for the MIPS CPU, replacing the fixed-program instruction ROM. The program is streamed in after reset through a valid/ready load port. The CPU is held off until a complete image is resident. Instruction fetch is a registered one-cycle-latency read with a valid flag, and unloaded addresses read as NOP.

---
 rtl/instruction_memory_loader.sv | 194 +++++++++++++++++++
 tb/tb_instruction_memory_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// instruction_memory_loader
//
// Loadable instruction memory for the MIPS CPU. After reset a program image is
// streamed in through a valid/ready load port. The CPU is stalled (cpu_hold)
// until a complete image is resident. Fetches are registered with one cycle of
// latency and carry a valid flag. Addresses beyond the loaded program read as
// NOP_WORD.
//
// Optional feature macro: IMEM_CHECKSUM_EN
//   When defined, the XOR of all loaded words is compared with load_checksum.
//   A mismatch sets the sticky load_error flag and returns to HOLD. When the
//   macro is undefined, load_checksum is ignored and load_error is tied low.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   load_start    one-cycle pulse that begins a load (ignored while loading)
//   load_len      word count, sampled on load_start, clamped to DEPTH
//   load_checksum expected XOR of the image, sampled on load_start
//   load_valid    load_data is valid
//   load_data     next instruction word
//   load_ready    block accepts load_data this cycle
//   load_error    sticky checksum-mismatch flag
//   cpu_hold      CPU must stall while high
//   fetch_en      fetch request
//   fetch_addr    fetch word address
//   fetch_data    registered instruction word
//   fetch_valid   fetch_data is valid
// -----------------------------------------------------------------------------
module instruction_memory_loader #(
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [DATA_WIDTH-1:0] load_checksum,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_error,
    output logic                  cpu_hold,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid
);

    localparam int            DEPTH    = 2 ** ADDR_WIDTH;
    localparam int            LW       = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_LW = LW'(DEPTH);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_reg;
    logic [LW-1:0]         len_reg;
    logic [LW-1:0]         ptr_reg;
    logic [LW-1:0]         program_len_reg;
    logic                  load_ready_reg;
    logic                  cpu_hold_reg;
    logic                  fetch_valid_reg;
    logic [DATA_WIDTH-1:0] fetch_data_reg;

    // Program storage; deliberately not reset. program_len_reg gating ensures
    // that stale or uninitialised contents are never returned.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic          accept;
    logic          last_word;
    logic          start_ok;
    logic          chk_fail;
    logic [LW-1:0] len_clamped;

    // load_ready_reg is high exactly while in LOAD, so it doubles as the
    // accept qualifier.
    assign accept      = load_ready_reg && load_valid;
    assign last_word   = accept && (ptr_reg == (len_reg - LW'(1)));
    assign start_ok    = load_start && (load_len != '0) && (state_reg != LOAD);
    assign len_clamped = (load_len > DEPTH_LW) ? DEPTH_LW : load_len;

`ifdef IMEM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xor_reg;
    logic [DATA_WIDTH-1:0] chk_reg;
    logic [DATA_WIDTH-1:0] xor_next;
    logic                  load_error_reg;

    // Checksum including the word being accepted this cycle, so the final
    // comparison is available in the same cycle as the last accept.
    assign xor_next = xor_reg ^ load_data;
    assign chk_fail = (xor_next != chk_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_reg        <= '0;
            chk_reg        <= '0;
            load_error_reg <= 1'b0;
        end else if (start_ok) begin
            xor_reg        <= '0;
            chk_reg        <= load_checksum;
            load_error_reg <= 1'b0;
        end else if (accept) begin
            xor_reg <= xor_next;
            if (last_word && chk_fail) begin
                load_error_reg <= 1'b1;
            end
        end
    end

    assign load_error = load_error_reg;
`else
    assign chk_fail = 1'b0;
    // load_checksum has no function in this build; folding it into a
    // constant-zero AND keeps the port formally used.
    assign load_error = &{1'b0, load_checksum};
`endif

    // Memory write port.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr_reg[ADDR_WIDTH-1:0]] <= load_data;
        end
    end

    // Control FSM and registered outputs, including the fetch read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= HOLD;
            len_reg         <= '0;
            ptr_reg         <= '0;
            program_len_reg <= '0;
            load_ready_reg  <= 1'b0;
            cpu_hold_reg    <= 1'b1;
            fetch_valid_reg <= 1'b0;
            fetch_data_reg  <= NOP_WORD;
        end else begin
            if ((state_reg == RUN) && fetch_en) begin
                fetch_valid_reg <= 1'b1;
                fetch_data_reg  <= ({1'b0, fetch_addr} < program_len_reg)
                                   ? mem[fetch_addr] : NOP_WORD;
            end else begin
                fetch_valid_reg <= 1'b0;
                fetch_data_reg  <= NOP_WORD;
            end

            case (state_reg)
                HOLD, RUN: begin
                    if (start_ok) begin
                        state_reg       <= LOAD;
                        ptr_reg         <= '0;
                        len_reg         <= len_clamped;
                        // Drop the old image immediately so nothing stale is
                        // served while the new one arrives.
                        program_len_reg <= '0;
                        load_ready_reg  <= 1'b1;
                        cpu_hold_reg    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ptr_reg <= ptr_reg + LW'(1);
                    end
                    if (last_word) begin
                        load_ready_reg <= 1'b0;
                        if (chk_fail) begin
                            state_reg <= HOLD;
                        end else begin
                            state_reg       <= RUN;
                            cpu_hold_reg    <= 1'b0;
                            program_len_reg <= len_reg;
                        end
                    end
                end
                default: begin
                    state_reg      <= HOLD;
                    load_ready_reg <= 1'b0;
                    cpu_hold_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready  = load_ready_reg;
    assign cpu_hold    = cpu_hold_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_data  = fetch_data_reg;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory_loader
//
// Self-checking bench for instruction_memory_loader (ADDR_WIDTH=3,
// DATA_WIDTH=32, NOP_WORD=0). Fetch expectations are pushed to a scoreboard
// queue when a request is driven and popped when the registered result
// appears. The checksum scenario is built only when IMEM_CHECKSUM_EN is
// defined.
// -----------------------------------------------------------------------------
module tb_instruction_memory_loader;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic [DW-1:0] load_checksum = '0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_ready;
    logic          load_error;
    logic          cpu_hold;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          addr;
        logic        valid;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] pw [12];
    logic [31:0] model_mem [DEPTH];
    int          model_len = 0;
    bit          model_run = 1'b0;

    instruction_memory_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NOP_WORD  (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_checksum(load_checksum),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_error   (load_error),
        .cpu_hold     (cpu_hold),
        .fetch_en     (fetch_en),
        .fetch_addr   (fetch_addr),
        .fetch_data   (fetch_data),
        .fetch_valid  (fetch_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // XOR of the first n words of the image under a mask.
    function automatic logic [31:0] image_xor(input int n, input logic [31:0] mask);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= (pw[i] ^ mask);
        return x;
    endfunction

    // Drives a back-to-back fetch burst; each request's expectation is queued
    // when driven and popped one cycle later when the result is registered.
    task automatic fetch_burst(input int addrs[$], input bit en);
        exp_t e;
        exp_t got;
        for (int i = 0; i < addrs.size(); i++) begin
            e.addr  = addrs[i];
            e.valid = model_run && en;
            e.data  = (e.valid && addrs[i] < model_len) ? model_mem[addrs[i]] : 32'h0;
            exp_q.push_back(e);
            fetch_en   = en;
            fetch_addr = 3'(addrs[i]);
            tick();
            got = exp_q.pop_front();
            checks++;
            if (fetch_valid !== got.valid || fetch_data !== got.data) begin
                failures++;
                $display("FAIL fetch addr=%0d en=%0d: got valid=%b data=%h, expected valid=%b data=%h",
                         got.addr, en, fetch_valid, fetch_data, got.valid, got.data);
            end else begin
                $display("fetch addr=%0d en=%0d valid=%b data=%h ok", got.addr, en, fetch_valid, fetch_data);
            end
        end
        fetch_en = 1'b0;
    endtask

    // Runs one load of `len` words (image words XOR mask). A junk word is
    // offered in the load_start cycle and must not be accepted.
    task automatic do_load(input int len, input logic [31:0] mask, input logic [31:0] chk,
                           input bit toggle, input bit expect_run);
        int cyc = 0;
        int idx = 0;
        int exp_n;
        bit acc;
        exp_n = (len > DEPTH) ? DEPTH : len;
        load_start    = 1'b1;
        load_len      = 4'(len);
        load_checksum = chk;
        load_valid    = 1'b1;
        load_data     = 32'hDEADBEEF;
        tick();
        load_start = 1'b0;
        checks++;
        if (load_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL load_enter: got ready=%b hold=%b, expected ready=1 hold=1", load_ready, cpu_hold);
        end
        while (load_ready === 1'b1 && cyc < 60) begin
            load_valid = toggle ? cyc[0] : 1'b1;
            load_data  = load_valid ? (pw[idx] ^ mask) : (32'hBAD00000 | 32'(cyc));
            acc = load_valid && load_ready;
            tick();
            if (acc) begin
                $display("load word %0d = %h accepted", idx, pw[idx] ^ mask);
                idx++;
            end
            if (load_ready === 1'b1) begin
                checks++;
                if (cpu_hold !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_during_load: got cpu_hold=%b, expected 1", cpu_hold);
                end
            end
            cyc++;
        end
        load_valid = 1'b0;
        checks++;
        if (idx != exp_n || cyc >= 60) begin
            failures++;
            $display("FAIL load_count: got %0d accepts in %0d cycles, expected %0d", idx, cyc, exp_n);
        end
        checks++;
        if (cpu_hold !== !expect_run || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_done: got hold=%b ready=%b, expected hold=%b ready=0",
                     cpu_hold, load_ready, !expect_run);
        end
        if (expect_run) begin
            for (int i = 0; i < exp_n; i++) model_mem[i] = pw[i] ^ mask;
            model_len = exp_n;
            model_run = 1'b1;
        end else begin
            model_len = 0;
            model_run = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (cpu_hold !== 1'b1 || load_ready !== 1'b0 || load_error !== 1'b0 ||
            fetch_valid !== 1'b0 || fetch_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_values: got hold=%b ready=%b err=%b fv=%b fd=%h, expected 1 0 0 0 0",
                     cpu_hold, load_ready, load_error, fetch_valid, fetch_data);
        end
        rst = 1'b0;
        tick();
        fetch_burst('{0}, 1'b1);
        checks++;
        if (cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: got cpu_hold=%b, expected 1", cpu_hold);
        end
    endtask

    task automatic test_basic_load();
        do_load(4, 32'h0, image_xor(4, 32'h0), 1'b0, 1'b1);
        fetch_burst('{0, 1, 2, 3, 5, 3}, 1'b1);
        fetch_burst('{1}, 1'b0);
    endtask

    task automatic test_zero_len_ignored();
        load_start = 1'b1;
        load_len   = '0;
        tick();
        load_start = 1'b0;
        checks++;
        if (cpu_hold !== 1'b0 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_len: got hold=%b ready=%b, expected hold=0 ready=0", cpu_hold, load_ready);
        end
        fetch_burst('{2}, 1'b1);
    endtask

    task automatic test_toggled_load();
        do_load(4, 32'h00A5_5A00, image_xor(4, 32'h00A5_5A00), 1'b1, 1'b1);
        fetch_burst('{3, 2, 1, 0, 4}, 1'b1);
    endtask

    task automatic test_clamp();
        do_load(12, 32'h0, image_xor(8, 32'h0), 1'b0, 1'b1);
        fetch_burst('{0, 1, 2, 3, 4, 5, 6, 7}, 1'b1);
    endtask

`ifdef IMEM_CHECKSUM_EN
    task automatic test_checksum();
        do_load(4, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (load_error !== 1'b1) begin
            failures++;
            $display("FAIL chk_bad: got load_error=%b, expected 1", load_error);
        end
        fetch_burst('{0}, 1'b1);
        do_load(4, 32'h0, image_xor(4, 32'h0), 1'b0, 1'b1);
        checks++;
        if (load_error !== 1'b0) begin
            failures++;
            $display("FAIL chk_good: got load_error=%b, expected 0", load_error);
        end
        fetch_burst('{0, 3}, 1'b1);
    endtask
`endif

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        load_len   = 4'd4;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = pw[0];
        tick();
        load_data  = pw[1];
        tick();
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0 || cpu_hold !== 1'b1 || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_load: got ready=%b hold=%b fv=%b, expected 0 1 0",
                     load_ready, cpu_hold, fetch_valid);
        end
        tick();
        rst = 1'b0;
        model_run = 1'b0;
        model_len = 0;
        tick();
        fetch_burst('{0, 1}, 1'b1);
    endtask

    initial begin
        pw[0]  = 32'h2C00000A; pw[1]  = 32'h2C010001; pw[2]  = 32'h08210001; pw[3]  = 32'h18017FFF;
        pw[4]  = 32'h11112222; pw[5]  = 32'h33334444; pw[6]  = 32'h55556666; pw[7]  = 32'h77778888;
        pw[8]  = 32'h9999AAAA; pw[9]  = 32'hBBBBCCCC; pw[10] = 32'hDDDDEEEE; pw[11] = 32'hFFFF0000;
        test_reset();
        test_basic_load();
        test_zero_len_ignored();
        test_toggled_load();
        test_clamp();
`ifdef IMEM_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
